// File: rtl/wb_commit_pipe.sv
// Writeback stage: priority-selects the committed result, registers it toward the register
// files and keeps a short history of committed writes for decode bypass lookups.
module wb_commit_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NSRC  = 5,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned REGW  = 5
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic                 hold,
  input  logic [NSRC-2:0]      src_sel,
  input  logic [NSRC*XLEN-1:0] src_data,
  input  logic [REGW-1:0]      rd,
  input  logic                 regwrite,
  input  logic                 fpusrc,
  output logic [XLEN-1:0]      wb_res,
  output logic [REGW-1:0]      wb_rd_q,
  output logic [XLEN-1:0]      wb_res_q,
  output logic                 wb_regwrite_q,
  output logic                 wb_fpusrc_q,
  input  logic [REGW-1:0]      lk_rs,
  input  logic                 lk_fp,
  output logic                 lk_hit,
  output logic [XLEN-1:0]      lk_data,
  output logic                 sel_err,
  output logic [31:0]          commit_cnt
);

  logic [DEPTH-1:0] we_q;
  logic [DEPTH-1:0] fp_q;
  logic [REGW-1:0]  rd_q  [DEPTH];
  logic [XLEN-1:0]  res_q [DEPTH];
  logic             sel_err_q;
  logic [31:0]      commit_cnt_q;

  logic accept;
  logic eff_we;
  logic multi_sel;

  assign accept = ~hold;
  assign eff_we = regwrite & ~(~fpusrc & (rd == '0));

  // Lowest asserted select wins; the last source is the fallback (ALU).
  always_comb begin
    logic found;
    logic seen;
    found     = 1'b0;
    seen      = 1'b0;
    multi_sel = 1'b0;
    wb_res    = src_data[(NSRC-1)*XLEN +: XLEN];
    for (int i = 0; i < int'(NSRC) - 1; i++) begin
      if (src_sel[i]) begin
        if (!found) begin
          wb_res = src_data[i*XLEN +: XLEN];
        end
        found     = 1'b1;
        multi_sel = multi_sel | seen;
        seen      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      we_q         <= '0;
      fp_q         <= '0;
      sel_err_q    <= 1'b0;
      commit_cnt_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        rd_q[k]  <= '0;
        res_q[k] <= '0;
      end
    end else if (accept) begin
      we_q[0]  <= eff_we;
      fp_q[0]  <= fpusrc;
      rd_q[0]  <= rd;
      res_q[0] <= wb_res;
      for (int k = 1; k < int'(DEPTH); k++) begin
        we_q[k]  <= we_q[k-1];
        fp_q[k]  <= fp_q[k-1];
        rd_q[k]  <= rd_q[k-1];
        res_q[k] <= res_q[k-1];
      end
      if (multi_sel) begin
        sel_err_q <= 1'b1;
      end
      if (eff_we) begin
        commit_cnt_q <= commit_cnt_q + 32'd1;
      end
    end
  end

  // Scan oldest to newest so the newest matching entry overrides.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (we_q[k] && (fp_q[k] == lk_fp) && (rd_q[k] == lk_rs) && !(!lk_fp && (lk_rs == '0))) begin
        lk_hit  = 1'b1;
        lk_data = res_q[k];
      end
    end
  end

  assign wb_rd_q       = rd_q[0];
  assign wb_res_q      = res_q[0];
  assign wb_regwrite_q = we_q[0];
  assign wb_fpusrc_q   = fp_q[0];
  assign sel_err       = sel_err_q;
  assign commit_cnt    = commit_cnt_q;

endmodule

// File: tb/tb_wb_commit_pipe.sv
// Directed bench for wb_commit_pipe (default parameters): vector table plus hold and
// reset-during-hold sequences.
module tb_wb_commit_pipe;

  logic         clk;
  logic         Rst;
  logic         hold;
  logic [3:0]   src_sel;
  logic [159:0] src_data;
  logic [4:0]   rd;
  logic         regwrite;
  logic         fpusrc;
  logic [31:0]  wb_res;
  logic [4:0]   wb_rd_q;
  logic [31:0]  wb_res_q;
  logic         wb_regwrite_q;
  logic         wb_fpusrc_q;
  logic [4:0]   lk_rs;
  logic         lk_fp;
  logic         lk_hit;
  logic [31:0]  lk_data;
  logic         sel_err;
  logic [31:0]  commit_cnt;

  int checks = 0;
  int errors = 0;

  wb_commit_pipe dut (
    .clk           (clk),
    .Rst           (Rst),
    .hold          (hold),
    .src_sel       (src_sel),
    .src_data      (src_data),
    .rd            (rd),
    .regwrite      (regwrite),
    .fpusrc        (fpusrc),
    .wb_res        (wb_res),
    .wb_rd_q       (wb_rd_q),
    .wb_res_q      (wb_res_q),
    .wb_regwrite_q (wb_regwrite_q),
    .wb_fpusrc_q   (wb_fpusrc_q),
    .lk_rs         (lk_rs),
    .lk_fp         (lk_fp),
    .lk_hit        (lk_hit),
    .lk_data       (lk_data),
    .sel_err       (sel_err),
    .commit_cnt    (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   sel;
    logic [159:0] data;
    logic [4:0]   rd;
    logic         rw;
    logic         fp;
    logic [4:0]   lrs;
    logic         lfp;
    logic [31:0]  e_res;
    logic [4:0]   e_rdq;
    logic [31:0]  e_resq;
    logic         e_we;
    logic         e_fp;
    logic         e_hit;
    logic [31:0]  e_data;
    logic         e_err;
    logic [31:0]  e_cnt;
  } vec_t;

  vec_t vt [12];

  function automatic logic [159:0] pk(input logic [31:0] d0, input logic [31:0] d1,
                                      input logic [31:0] d2, input logic [31:0] d3,
                                      input logic [31:0] d4);
    return {d4, d3, d2, d1, d0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] sel, input logic [159:0] data, input logic [4:0] r,
                       input logic rw, input logic fp, input logic [4:0] lrs, input logic lfp);
    src_sel  = sel;
    src_data = data;
    rd       = r;
    regwrite = rw;
    fpusrc   = fp;
    lk_rs    = lrs;
    lk_fp    = lfp;
  endtask

  task automatic chk_regs(input string tag, input logic [4:0] e_rdq, input logic [31:0] e_resq,
                          input logic e_we, input logic e_fp, input logic e_hit,
                          input logic [31:0] e_data, input logic e_err, input logic [31:0] e_cnt);
    chk({tag, " wb_rd_q"}, 32'(wb_rd_q), 32'(e_rdq));
    chk({tag, " wb_res_q"}, wb_res_q, e_resq);
    chk({tag, " wb_regwrite_q"}, 32'(wb_regwrite_q), 32'(e_we));
    chk({tag, " wb_fpusrc_q"}, 32'(wb_fpusrc_q), 32'(e_fp));
    chk({tag, " lk_hit"}, 32'(lk_hit), 32'(e_hit));
    chk({tag, " lk_data"}, lk_data, e_data);
    chk({tag, " sel_err"}, 32'(sel_err), 32'(e_err));
    chk({tag, " commit_cnt"}, commit_cnt, e_cnt);
  endtask

  initial begin
    // sel data rd rw fp lrs lfp | res rdq resq we fp hit data err cnt
    vt[0]  = '{4'b0000, pk(32'h100, 32'h101, 32'h102, 32'h103, 32'hDEADBEEF), 5'd3, 1'b1, 1'b0,
               5'd3, 1'b0, 32'hDEADBEEF, 5'd3, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF,
               1'b0, 32'd1};
    vt[1]  = '{4'b0100, pk(32'h100, 32'h101, 32'h22, 32'h103, 32'h200), 5'd6, 1'b1, 1'b0,
               5'd3, 1'b0, 32'h22, 5'd6, 32'h22, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'd2};
    vt[2]  = '{4'b0001, pk(32'h55, 32'h101, 32'h102, 32'h103, 32'h200), 5'd0, 1'b1, 1'b0,
               5'd0, 1'b0, 32'h55, 5'd0, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd2};
    vt[3]  = '{4'b0010, pk(32'h100, 32'h66, 32'h102, 32'h103, 32'h200), 5'd0, 1'b1, 1'b1,
               5'd0, 1'b1, 32'h66, 5'd0, 32'h66, 1'b1, 1'b1, 1'b1, 32'h66, 1'b0, 32'd3};
    vt[4]  = '{4'b0000, pk(32'h100, 32'h101, 32'h102, 32'h103, 32'hA), 5'd7, 1'b1, 1'b0,
               5'd7, 1'b0, 32'hA, 5'd7, 32'hA, 1'b1, 1'b0, 1'b1, 32'hA, 1'b0, 32'd4};
    vt[5]  = '{4'b1000, pk(32'h100, 32'h101, 32'h102, 32'hB, 32'h200), 5'd7, 1'b1, 1'b0,
               5'd7, 1'b0, 32'hB, 5'd7, 32'hB, 1'b1, 1'b0, 1'b1, 32'hB, 1'b0, 32'd5};
    vt[6]  = '{4'b0000, pk(32'h100, 32'h101, 32'h102, 32'h103, 32'hC), 5'd8, 1'b1, 1'b0,
               5'd7, 1'b0, 32'hC, 5'd8, 32'hC, 1'b1, 1'b0, 1'b1, 32'hB, 1'b0, 32'd6};
    vt[7]  = '{4'b0000, pk(32'h100, 32'h101, 32'h102, 32'h103, 32'hD), 5'd9, 1'b1, 1'b0,
               5'd7, 1'b0, 32'hD, 5'd9, 32'hD, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'd7};
    vt[8]  = '{4'b0000, pk(32'h100, 32'h101, 32'h102, 32'h103, 32'hE), 5'd9, 1'b0, 1'b0,
               5'd9, 1'b0, 32'hE, 5'd9, 32'hE, 1'b0, 1'b0, 1'b1, 32'hD, 1'b0, 32'd7};
    vt[9]  = '{4'b0000, pk(32'h100, 32'h101, 32'h102, 32'h103, 32'h77), 5'd9, 1'b1, 1'b1,
               5'd9, 1'b0, 32'h77, 5'd9, 32'h77, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'd8};
    vt[10] = '{4'b0110, pk(32'h100, 32'h11, 32'h22, 32'h103, 32'h200), 5'd5, 1'b1, 1'b0,
               5'd5, 1'b0, 32'h11, 5'd5, 32'h11, 1'b1, 1'b0, 1'b1, 32'h11, 1'b1, 32'd9};
    vt[11] = '{4'b0000, pk(32'h100, 32'h101, 32'h102, 32'h103, 32'h1234), 5'd10, 1'b1, 1'b0,
               5'd5, 1'b0, 32'h1234, 5'd10, 32'h1234, 1'b1, 1'b0, 1'b1, 32'h11, 1'b1, 32'd10};

    Rst  = 1'b1;
    hold = 1'b0;
    drive(4'b0000, '0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk_regs("reset", 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0);
    Rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vt[i].sel, vt[i].data, vt[i].rd, vt[i].rw, vt[i].fp, vt[i].lrs, vt[i].lfp);
      #1;
      chk($sformatf("v%0d wb_res", i), wb_res, vt[i].e_res);
      @(posedge clk);
      #1;
      chk_regs($sformatf("v%0d", i), vt[i].e_rdq, vt[i].e_resq, vt[i].e_we, vt[i].e_fp,
               vt[i].e_hit, vt[i].e_data, vt[i].e_err, vt[i].e_cnt);
    end

    // Hold: commit x4 <- 5, then freeze for three cycles while inputs change.
    drive(4'b0000, pk(32'h100, 32'h101, 32'h102, 32'h103, 32'h5), 5'd4, 1'b1, 1'b0, 5'd4, 1'b0);
    @(posedge clk);
    #1;
    chk_regs("hold pre", 5'd4, 32'h5, 1'b1, 1'b0, 1'b1, 32'h5, 1'b1, 32'd11);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, pk(32'h100, 32'h101, 32'h102, 32'h103, 32'h300 + 32'(i)), 5'(12 + i), 1'b1,
            1'b0, 5'd4, 1'b0);
      #1;
      chk($sformatf("hold%0d wb_res", i), wb_res, 32'h300 + 32'(i));
      @(posedge clk);
      #1;
      chk_regs($sformatf("hold%0d", i), 5'd4, 32'h5, 1'b1, 1'b0, 1'b1, 32'h5, 1'b1, 32'd11);
    end
    hold = 1'b0;
    drive(4'b0000, pk(32'h100, 32'h101, 32'h102, 32'h103, 32'h99), 5'd12, 1'b1, 1'b0, 5'd4, 1'b0);
    @(posedge clk);
    #1;
    chk_regs("release", 5'd12, 32'h99, 1'b1, 1'b0, 1'b1, 32'h5, 1'b1, 32'd12);

    // Reset asserted together with hold must still clear everything.
    Rst  = 1'b1;
    hold = 1'b1;
    lk_rs = 5'd12;
    @(posedge clk);
    #1;
    chk_regs("rst+hold", 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0);
    lk_rs = 5'd4;
    #1;
    chk("rst+hold lk_hit x4", 32'(lk_hit), 32'd0);
    Rst  = 1'b0;
    hold = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_commit_pipe.md
# wb_commit_pipe

Parametrised writeback stage for the RISC-V pipeline. It selects the committed result from NSRC producer sources (memory, CSR, multiplier, divider, ..., ALU), registers it toward the register files, and keeps a DEPTH-entry history of committed writes. Decode uses that history for bypass lookups. It sits between the MEM/WB pipeline register and the integer/FP register files.

## Interface
Parameters:
- XLEN, 32, datapath width
- NSRC, 5, number of result sources; index NSRC-1 is the default (ALU) source
- DEPTH, 2, number of committed-write history entries (≥1)
- REGW, 5, register index width

Ports:
- clk  in  1  clock
- Rst  in  1  synchronous, active-high reset
- hold  in  1  freeze: OR of debug halt, memory hold and FPU stall
- src_sel  in  NSRC-1  per-source select for sources 0..NSRC-2 (e.g. memread, CSR_read, mul_ready, div_ready)
- src_data  in  NSRC*XLEN  concatenated source results; source i occupies bits [i*XLEN +: XLEN]
- rd  in  REGW  destination register of the instruction in WB
- regwrite  in  1  instruction writes a register
- fpusrc  in  1  destination is the FP register file
- wb_res  out  XLEN  combinational selected result
- wb_rd_q  out  REGW  registered destination (history entry 0)
- wb_res_q  out  XLEN  registered result (entry 0)
- wb_regwrite_q  out  1  registered write enable (entry 0)
- wb_fpusrc_q  out  1  registered FP flag (entry 0)
- lk_rs  in  REGW  bypass lookup register index
- lk_fp  in  1  lookup targets the FP file
- lk_hit  out  1  some valid history entry matches
- lk_data  out  XLEN  data of the newest matching entry; 0 when no hit
- sel_err  out  1  sticky: more than one src_sel bit asserted in an accepted cycle
- commit_cnt  out  32  count of accepted cycles with effective regwrite=1

## Operation
- Source select: the lowest-index asserted src_sel bit wins. If no bit is asserted, source NSRC-1 is selected. wb_res is the selected data, purely combinational.
- Effective write enable: eff_we = regwrite & ~(~fpusrc & rd==0). Integer x0 is never written; FP f0 is writable.
- History: entries 0..DEPTH-1 each hold {we, fp, rd, res}. On an accepted cycle (~Rst & ~hold):
  - entry 0 ← {eff_we, fpusrc, rd, wb_res}
  - entry k ← entry k-1 for k ≥ 1
- *_q outputs are the fields of entry 0.
- hold=1: all entries, sel_err and commit_cnt keep their values. wb_res still tracks its inputs.
- Lookup (combinational): entry k matches when we_k=1, fp_k==lk_fp and rd_k==lk_rs. Integer lk_rs=0 never hits. lk_data comes from the lowest matching k (newest entry).
- sel_err: set on an accepted cycle when popcount(src_sel) > 1. Cleared only by Rst.
- commit_cnt: increments by 1 on each accepted cycle with eff_we=1. Wraps from 0xFFFFFFFF to 0.
- Reset: all history fields are 0, including the fp flags. The *_q outputs, sel_err and commit_cnt are 0, so lk_hit=0.

## Timing
- Selection latency is 0 cycles (wb_res).
- Registered outputs and history entry 0 update 1 cycle after an accepted cycle.
- Entry k holds the write accepted k+1 accepted cycles earlier. Held cycles do not age entries.
- Lookup is same-cycle combinational against the current history. It does not see the in-flight wb_res; decode bypasses that separately.
- Rst beats hold: when both are asserted, the block resets.
- Rst asserted mid-stream clears all history on that edge. lk_hit=0 in the following cycle.
- For DEPTH=1 the history is just the *_q registers.

## Test plan
- Priority: src_sel=0b0110, src_data[1]=0x11, src_data[2]=0x22, regwrite=1, rd=5 → wb_res=0x11, wb_res_q=0x11, wb_rd_q=5 next cycle, sel_err=1 (sticky until Rst).
- Default source: src_sel=0, ALU data 0xDEADBEEF, rd=3 → wb_res=0xDEADBEEF. After one edge: wb_regwrite_q=1, commit_cnt=1.
- x0/f0 rules:
  - rd=0, fpusrc=0, regwrite=1 → wb_regwrite_q=0, commit_cnt unchanged, lookup of rs=0 misses.
  - Same with fpusrc=1 → wb_regwrite_q=1, lookup lk_fp=1, lk_rs=0 hits.
- History/newest-wins (DEPTH=2): commit x7←0xA, then x7←0xB → lk_rs=7 returns 0xB. Next, commit x8←0xC → lk_rs=7 still returns 0xB from entry 1. After a further commit to x9, x7 misses.
- Hold: commit x4←0x5; hold=1 for 3 cycles while inputs change → *_q, lookup and commit_cnt are frozen. Release → the next input is accepted on the following edge.
- Reset mid-stream: fill history, assert Rst together with hold=1 → all *_q=0, lk_hit=0, sel_err=0 and commit_cnt=0 on the next cycle.
